load_store_unit: RTL and testbench

//  Execute/memory-stage LSU downstream of the function decoder. Consumes the registered is_LS

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit_align.sv | 47 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: is_LS field positions, access size codes,
// FSM state encoding and the alignment rule used by the optional misalign check.
package load_store_unit_pkg;

    localparam int LSU_XLEN     = 32;
    localparam int LSU_ADDR_W   = 32;
    localparam int LS_VALID_BIT = 3;
    localparam int LS_STORE_BIT = 2;

    typedef enum logic [1:0] {
        LS_NONE = 2'b00,
        LS_BYTE = 2'b01,
        LS_HALF = 2'b10,
        LS_WORD = 2'b11
    } ls_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } lsu_state_e;

    function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] lo);
        return ((size == LS_HALF) && lo[0]) || ((size == LS_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the LSU: req/gnt request phase plus rvld load-data return.
interface load_store_unit_if
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int ADDR_W = LSU_ADDR_W
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvld;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvld, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvld, dmem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store-data replication and load
// extraction with sign/zero extension.
module load_store_unit_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
)
(
    input  ls_size_e        size,
    input  logic [1:0]      lo,
    input  logic            lsign,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{lo, 3'b000} +: 8];
    assign half_sel = rdata[{lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            LS_BYTE: begin
                be        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{(XLEN-8){lsign & byte_sel[7]}}, byte_sel};
            end
            LS_HALF: begin
                be        = 4'b0011 << {lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{(XLEN-16){lsign & half_sel[15]}}, half_sel};
            end
            LS_WORD: begin
                be = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute/memory-stage load/store unit with a req/gnt/rvld data-memory port.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word ops are dropped and flagged.
//
// state   | meaning
// IDLE    | no access in flight; new op may be accepted
// REQ     | dmem_req held with stable fields until dmem_gnt
// WAIT    | load granted, waiting for dmem_rvld
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int ADDR_W = LSU_ADDR_W
)
(
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [3:0]        ls_ctrl,
    input  logic              ls_lsign,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [4:0]        ls_rd,
    input  logic              ls_flush,
    output logic              lsu_busy,
    load_store_unit_if.master dmem,
    output logic              wb_vld,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              lsu_misalign,
    output logic [ADDR_W-1:0] lsu_bad_addr
);

    lsu_state_e        state, state_nxt;
    ls_size_e          op_size, size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              sign_q, store_q;
    logic [4:0]        rd_q;
    logic              accept, bad_align, launch, in_req;
    logic [3:0]        be_w;
    logic [XLEN-1:0]   wdata_w, rdata_w;

    assign op_size = ls_size_e'(ls_ctrl[1:0]);
    assign accept  = (state == ST_IDLE) && ls_ctrl[LS_VALID_BIT] && !ls_flush;

`ifdef LSU_MISALIGN_CHECK_EN
    assign bad_align = is_misaligned(op_size, ls_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    // Size 00 and misaligned ops freeze only the accept cycle and never leave IDLE.
    assign launch   = accept && (op_size != LS_NONE) && !bad_align;
    assign lsu_busy = (state != ST_IDLE) || accept;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch)        state_nxt = ST_REQ;
            ST_REQ:  if (dmem.dmem_gnt) state_nxt = store_q ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dmem.dmem_rvld) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= LS_NONE;
            sign_q  <= 1'b0;
            store_q <= 1'b0;
            rd_q    <= '0;
        end else if (launch) begin
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            size_q  <= op_size;
            sign_q  <= ls_lsign;
            store_q <= ls_ctrl[LS_STORE_BIT];
            rd_q    <= ls_rd;
        end
    end

    load_store_unit_align #(.XLEN(XLEN)) u_align (
        .size      (size_q),
        .lo        (addr_q[1:0]),
        .lsign     (sign_q),
        .wdata     (wdata_q),
        .rdata     (dmem.dmem_rdata),
        .be        (be_w),
        .wdata_rep (wdata_w),
        .rdata_ext (rdata_w)
    );

    assign in_req          = (state == ST_REQ);
    assign dmem.dmem_req   = in_req;
    assign dmem.dmem_we    = in_req && store_q;
    assign dmem.dmem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = in_req ? be_w : 4'b0000;
    assign dmem.dmem_wdata = in_req ? wdata_w : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wb_vld  <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_vld <= (state == ST_WAIT) && dmem.dmem_rvld;
            if ((state == ST_WAIT) && dmem.dmem_rvld) begin
                wb_rd   <= rd_q;
                wb_data <= rdata_w;
            end
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic              misalign_q;
    logic [ADDR_W-1:0] bad_addr_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            misalign_q <= accept && bad_align;
            if (accept && bad_align) bad_addr_q <= ls_addr;
        end
    end

    assign lsu_misalign = misalign_q;
    assign lsu_bad_addr = bad_addr_q;
`else
    assign lsu_misalign = 1'b0;
    assign lsu_bad_addr = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level
// reference model of lanes, replication and load extension.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [3:0]  ls_ctrl = '0;
    logic        ls_lsign = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [4:0]  ls_rd = '0;
    logic        ls_flush = 1'b0;
    logic        lsu_busy;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_misalign;
    logic [31:0] lsu_bad_addr;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit_if dmem ();

    load_store_unit dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .ls_ctrl      (ls_ctrl),
        .ls_lsign     (ls_lsign),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_rd        (ls_rd),
        .ls_flush     (ls_flush),
        .lsu_busy     (lsu_busy),
        .dmem         (dmem),
        .wb_vld       (wb_vld),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lsu_misalign (lsu_misalign),
        .lsu_bad_addr (lsu_bad_addr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: accesses seen as a run of n bytes starting at lane 'off'.
    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
    endfunction

    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes_of(sz);
        int lo = int'(a % 4);
        return lo - (lo % n);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m = '0;
        int n = nbytes_of(sz);
        int off = lane_off(sz, a);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes_of(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                               input logic sgn, input logic [31:0] rdata);
        longint v = 0;
        int n = nbytes_of(sz);
        int off = lane_off(sz, a);
        for (int j = 0; j < n; j++) v = v + (longint'(rdata[8*(off+j) +: 8]) << (8*j));
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},   dmem.dmem_req, 0);
        check({tag, "_we"},    dmem.dmem_we, 0);
        check({tag, "_addr"},  dmem.dmem_addr, 0);
        check({tag, "_be"},    dmem.dmem_be, 0);
        check({tag, "_wdata"}, dmem.dmem_wdata, 0);
        check({tag, "_busy"},  lsu_busy, 0);
        check({tag, "_wbv"},   wb_vld, 0);
        check({tag, "_wbd"},   wb_data, 0);
        check({tag, "_wbrd"},  wb_rd, 0);
        check({tag, "_mis"},   lsu_misalign, 0);
        check({tag, "_bad"},   lsu_bad_addr, 0);
    endtask

    // One complete access; junk ops and flushes are offered while it is in flight.
    task automatic run_op(input logic st, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                          input int gwait, input int rwait, input logic [4:0] rd);
        @(negedge CLK);
        ls_ctrl = {1'b1, st, sz}; ls_lsign = sgn; ls_addr = a; ls_wdata = d; ls_rd = rd; ls_flush = 1'b0;
        #1 check("busy_accept", lsu_busy, 1);
        for (int k = 0; k <= gwait; k++) begin
            @(negedge CLK);
            ls_ctrl = 4'($urandom) | 4'b1000; ls_flush = 1'($urandom);
            ls_addr = $urandom; ls_wdata = $urandom; ls_rd = 5'($urandom);
            dmem.dmem_gnt = (k == gwait);
            #1;
            check("req", dmem.dmem_req, 1);
            check("we", dmem.dmem_we, st);
            check("addr", dmem.dmem_addr, a & 32'hFFFF_FFFC);
            check("be", dmem.dmem_be, model_be(sz, a));
            if (st) check("wdata", dmem.dmem_wdata, model_wdata(sz, d));
            check("busy_req", lsu_busy, 1);
            check("wb_in_req", wb_vld, 0);
        end
        @(negedge CLK);
        dmem.dmem_gnt = 1'b0;
        if (st) begin
            ls_ctrl = '0; ls_flush = 1'b0;
            #1;
            check("st_done_req", dmem.dmem_req, 0);
            check("st_done_busy", lsu_busy, 0);
            check("st_no_wb", wb_vld, 0);
            @(negedge CLK);
            #1 check("st_no_wb2", wb_vld, 0);
        end else begin
            for (int k = 0; k <= rwait; k++) begin
                if (k > 0) @(negedge CLK);
                dmem.dmem_rvld  = (k == rwait);
                dmem.dmem_rdata = (k == rwait) ? rdata : $urandom;
                #1;
                check("wait_req", dmem.dmem_req, 0);
                check("wait_busy", lsu_busy, 1);
                check("wait_wb", wb_vld, 0);
            end
            @(negedge CLK);
            dmem.dmem_rvld = 1'b0; dmem.dmem_rdata = $urandom;
            ls_ctrl = '0; ls_flush = 1'b0;
            #1;
            check("wb_vld", wb_vld, 1);
            check("wb_data", wb_data, model_load(sz, a, sgn, rdata));
            check("wb_rd", wb_rd, rd);
            check("wb_busy", lsu_busy, 0);
            check("wb_mis", lsu_misalign, 0);
            @(negedge CLK);
            #1 check("wb_pulse", wb_vld, 0);
        end
    endtask

    task automatic run_flush(input logic [31:0] a);
        @(negedge CLK);
        ls_ctrl = {1'b1, 1'($urandom), 2'($urandom_range(1, 3))}; ls_addr = a; ls_flush = 1'b1;
        #1 check("flush_busy", lsu_busy, 0);
        @(negedge CLK);
        ls_ctrl = '0; ls_flush = 1'b0;
        #1;
        check("flush_req", dmem.dmem_req, 0);
        check("flush_busy2", lsu_busy, 0);
    endtask

    task automatic run_nop(input logic [31:0] a);
        @(negedge CLK);
        ls_ctrl = {1'b1, 1'($urandom), 2'b00}; ls_addr = a; ls_flush = 1'b0;
        #1 check("nop_busy", lsu_busy, 1);
        @(negedge CLK);
        ls_ctrl = '0;
        #1;
        check("nop_req", dmem.dmem_req, 0);
        check("nop_busy2", lsu_busy, 0);
        @(negedge CLK);
        #1;
        check("nop_req2", dmem.dmem_req, 0);
        check("nop_wb", wb_vld, 0);
    endtask

    task automatic run_reset_mid_load();
        @(negedge CLK);
        ls_ctrl = 4'b1011; ls_lsign = 1'b0; ls_addr = 32'h200; ls_rd = 5'd7;
        @(negedge CLK);
        ls_ctrl = '0; dmem.dmem_gnt = 1'b1;
        @(negedge CLK);
        dmem.dmem_gnt = 1'b0;
        #1 check("rst_wait_busy", lsu_busy, 1);
        RSTN = 1'b0;
        #1 check_idle_outputs("rst_mid");
        @(negedge CLK);
        RSTN = 1'b1;
        dmem.dmem_rvld = 1'b1; dmem.dmem_rdata = 32'hCAFE_F00D;
        @(negedge CLK);
        dmem.dmem_rvld = 1'b0;
        #1;
        check("rst_late_rvld_wb", wb_vld, 0);
        check("rst_late_busy", lsu_busy, 0);
        check("rst_late_req", dmem.dmem_req, 0);
        check("rst_late_wbd", wb_data, 0);
    endtask

    task automatic run_lw_misaligned();
`ifdef LSU_MISALIGN_CHECK_EN
        @(negedge CLK);
        ls_ctrl = 4'b1011; ls_addr = 32'h102; ls_flush = 1'b0;
        #1 check("mis_accept_busy", lsu_busy, 1);
        @(negedge CLK);
        ls_ctrl = '0;
        #1;
        check("mis_req", dmem.dmem_req, 0);
        check("mis_pulse", lsu_misalign, 1);
        check("mis_bad_addr", lsu_bad_addr, 32'h102);
        check("mis_busy", lsu_busy, 0);
        check("mis_wb", wb_vld, 0);
        @(negedge CLK);
        #1;
        check("mis_pulse_end", lsu_misalign, 0);
        check("mis_bad_hold", lsu_bad_addr, 32'h102);
        check("mis_req2", dmem.dmem_req, 0);
`else
        run_op(1'b0, 2'b11, 1'b0, 32'h102, 32'h0, 32'h1122_3344, 0, 0, 5'd9);
        check("nomis_flag", lsu_misalign, 0);
        check("nomis_bad", lsu_bad_addr, 0);
`endif
    endtask

    initial begin
        logic        st, sgn;
        logic [1:0]  sz;
        logic [31:0] a, d, rdata;
        int          sel;

        dmem.dmem_gnt = 1'b0; dmem.dmem_rvld = 1'b0; dmem.dmem_rdata = '0;
        repeat (3) @(negedge CLK);
        #1 check_idle_outputs("reset");
        @(negedge CLK);
        RSTN = 1'b1;

        run_op(1'b1, 2'b11, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 5'd0);
        run_op(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 5'd0);
        run_op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h1234_80FF, 0, 0, 5'd3);
        run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h1234_80FF, 0, 0, 5'd4);
        run_op(1'b0, 2'b10, 1'b1, 32'h102, 32'h0, 32'h8001_0000, 3, 0, 5'd5);
        run_reset_mid_load();
        run_lw_misaligned();
        run_nop(32'h40);
        run_flush(32'h80);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) run_flush($urandom);
            else if (sel == 1) run_nop($urandom);
            else begin
                st  = 1'($urandom);
                sz  = 2'($urandom_range(1, 3));
                sgn = 1'($urandom);
                a   = $urandom;
                a   = a - (a % nbytes_of(sz));
                d   = $urandom;
                rdata = $urandom;
                run_op(st, sz, sgn, a, d, rdata, $urandom_range(0, 3), $urandom_range(0, 3),
                       5'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
